// File: rtl/repairmb_initiator_if.sv
// Sideband message and lane-test handshake bundle for the REPAIRMB initiator.
// The master modport is the initiator's view; the slave modport faces the sideband and lane tester.
interface repairmb_initiator_if;
  logic       i_Busy_SideBand;
  logic       i_falling_edge_busy;
  logic [3:0] i_RX_SbMessage;
  logic       i_msg_valid;
  logic       i_Start_Repeater;
  logic [1:0] i_Lanes_Result;
  logic       i_Lanes_Result_valid;
  logic       o_Start_Lane_Test;
  logic       o_Done_Repeater;
  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutData;
  logic [1:0] o_msg_info_Lanes;

  modport master (
    input  i_Busy_SideBand, i_falling_edge_busy, i_RX_SbMessage, i_msg_valid,
    input  i_Start_Repeater, i_Lanes_Result, i_Lanes_Result_valid,
    output o_Start_Lane_Test, o_Done_Repeater, o_TX_SbMessage, o_ValidOutData,
    output o_msg_info_Lanes
  );

  modport slave (
    output i_Busy_SideBand, i_falling_edge_busy, i_RX_SbMessage, i_msg_valid,
    output i_Start_Repeater, i_Lanes_Result, i_Lanes_Result_valid,
    input  o_Start_Lane_Test, o_Done_Repeater, o_TX_SbMessage, o_ValidOutData,
    input  o_msg_info_Lanes
  );
endinterface

// File: rtl/repairmb_initiator.sv
// MBINIT.REPAIRMB initiator: start handshake, lane test, degrade apply with one partner repeat,
// end handshake. All outputs are registered and decoded from the next state.
module repairmb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16'd8000,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 MBINIT_REVERSALMB_end,
  repairmb_initiator_if.master sb,
  output logic [1:0]           o_Functional_Lanes,
  output logic                 o_train_error,
  output logic                 o_MBINIT_REPAIRMB_end
);
  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [3:0] MsgStartReq  = 4'd1;
  localparam logic [3:0] MsgStartResp = 4'd2;
  localparam logic [3:0] MsgEndReq    = 4'd3;
  localparam logic [3:0] MsgEndResp   = 4'd4;
  localparam logic [3:0] MsgDegReq    = 4'd5;
  localparam logic [3:0] MsgDegResp   = 4'd6;

  typedef enum logic [3:0] {
    StIdle, StBusyStart, StStartReq, StWaitStartResp, StLaneTest, StBusyDegrade, StDegradeReq,
    StWaitDegradeResp, StDecide, StBusyEnd, StEndReq, StWaitEndResp, StDone, StError
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [1:0]       lanes_q, lanes_d;
  logic [1:0]       func_q, func_d;
  logic [3:0]       tx_q, tx_d;
  logic [1:0]       info_q, info_d;
  logic             rep_q, rep_d;
  logic             valid_q, valid_d;
  logic             slt_q, slt_d;
  logic             drep_q, drep_d;
  logic             err_q, err_d;
  logic             end_q, end_d;
  logic             timeout, entering;

  function automatic logic got(input logic v, input logic [3:0] rx, input logic [3:0] code);
    return v && (rx == code);
  endfunction

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    rep_d   = rep_q;
    timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    unique case (state_q)
      StIdle:        state_d = StBusyStart;
      StBusyStart:   if (!sb.i_Busy_SideBand) state_d = StStartReq;
      StStartReq:    if (sb.i_falling_edge_busy) state_d = StWaitStartResp;
      StWaitStartResp: begin
        // A response arriving on the timeout cycle still wins.
        if (got(sb.i_msg_valid, sb.i_RX_SbMessage, MsgStartResp)) state_d = StLaneTest;
        else if (timeout) state_d = StError;
      end
      StLaneTest: begin
        if (sb.i_Lanes_Result_valid) begin
          lanes_d = sb.i_Lanes_Result;
          state_d = (sb.i_Lanes_Result == 2'b00) ? StError : StBusyDegrade;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StBusyDegrade: if (!sb.i_Busy_SideBand) state_d = StDegradeReq;
      StDegradeReq:  if (sb.i_falling_edge_busy) state_d = StWaitDegradeResp;
      StWaitDegradeResp: begin
        if (got(sb.i_msg_valid, sb.i_RX_SbMessage, MsgDegResp)) state_d = StDecide;
        else if (timeout) state_d = StError;
      end
      StDecide: begin
        if (sb.i_Start_Repeater) begin
          if (rep_q) begin
            state_d = StError;
          end else begin
            rep_d   = 1'b1;
            state_d = StLaneTest;
          end
        end else if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
          state_d = StBusyEnd;
        end
      end
      StBusyEnd:     if (!sb.i_Busy_SideBand) state_d = StEndReq;
      StEndReq:      if (sb.i_falling_edge_busy) state_d = StWaitEndResp;
      StWaitEndResp: begin
        if (got(sb.i_msg_valid, sb.i_RX_SbMessage, MsgEndResp)) state_d = StDone;
        else if (timeout) state_d = StError;
      end
      StDone, StError: ;
      default:       state_d = StIdle;
    endcase

    if (!MBINIT_REVERSALMB_end) begin
      state_d = StIdle;
      rep_d   = 1'b0;
    end

    entering = (state_d != state_q);
    if (entering || !(state_q inside {StWaitStartResp, StLaneTest, StWaitDegradeResp,
                                       StWaitEndResp})) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    gcnt_d = (entering || state_q != StDecide) ? '0 : gcnt_q + GW'(1);

    func_d = (state_q == StWaitDegradeResp && state_d == StDecide) ? lanes_q : func_q;

    valid_d = entering && (state_d inside {StStartReq, StDegradeReq, StEndReq});
    slt_d   = entering && (state_d == StLaneTest);
    drep_d  = (state_q == StLaneTest) && (state_d == StBusyDegrade) && rep_q;
    err_d   = (state_d == StError);
    end_d   = (state_d == StDone);

    tx_d   = tx_q;
    info_d = info_q;
    if (state_d == StIdle) begin
      tx_d   = '0;
      info_d = '0;
    end else if (entering) begin
      case (state_d)
        StStartReq:   tx_d = MsgStartReq;
        StDegradeReq: begin
          tx_d   = MsgDegReq;
          info_d = lanes_q;
        end
        StEndReq:     tx_d = MsgEndReq;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      lanes_q <= 2'b00;
      func_q  <= 2'b11;
      tx_q    <= '0;
      info_q  <= '0;
      rep_q   <= 1'b0;
      valid_q <= 1'b0;
      slt_q   <= 1'b0;
      drep_q  <= 1'b0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      lanes_q <= lanes_d;
      func_q  <= func_d;
      tx_q    <= tx_d;
      info_q  <= info_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      slt_q   <= slt_d;
      drep_q  <= drep_d;
      err_q   <= err_d;
      end_q   <= end_d;
    end
  end

  assign sb.o_Start_Lane_Test  = slt_q;
  assign sb.o_Done_Repeater    = drep_q;
  assign sb.o_TX_SbMessage     = tx_q;
  assign sb.o_ValidOutData     = valid_q;
  assign sb.o_msg_info_Lanes   = info_q;
  assign o_Functional_Lanes    = func_q;
  assign o_train_error         = err_q;
  assign o_MBINIT_REPAIRMB_end = end_q;
endmodule

// File: tb/tb_repairmb_initiator.sv
// Bench for repairmb_initiator: a reactive partner drives scenarios from a table and from random
// draws; a transaction-level model predicts the sent messages, pulses and final status.
module tb_repairmb_initiator;
  localparam int unsigned TO = 20;
  localparam int unsigned GD = 4;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] func;
  logic       err, fin;

  repairmb_initiator_if sb_if ();

  repairmb_initiator #(.TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GD), .CNT_W(16)) dut (
    .CLK                   (CLK),
    .rst_n                 (rst_n),
    .MBINIT_REVERSALMB_end (en),
    .sb                    (sb_if),
    .o_Functional_Lanes    (func),
    .o_train_error         (err),
    .o_MBINIT_REPAIRMB_end (fin)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit do_reset;
    logic [1:0] r1; bit rep; logic [1:0] r2; bit rep2;
    bit drop; bit abort; bit garbage;
    int pre_busy; int busy_len; int resp_dly; int lt_dly;
    bit has_exp; logic [1:0] exp_func; bit exp_err; bit exp_end;
  } scen_t;

  int checks = 0;
  int errors = 0;

  logic [3:0] act_msg[$];
  logic [1:0] act_info[$];
  int         act_lt, act_done, busy_viol, fe_idx, err_idx;
  bit         expired;

  logic [3:0] exp_msg[$];
  logic [1:0] exp_info[$];
  int         exp_lt, exp_done;
  logic [1:0] m_func, model_func;
  bit         m_err, m_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic scen_t mk(input bit rst, input logic [1:0] r1, input bit rep,
                               input logic [1:0] r2, input bit rep2, input bit drop,
                               input bit abort, input bit garb, input int pre, input int blen,
                               input int rdly, input int ldly, input logic [1:0] efunc,
                               input bit eerr, input bit eend);
    scen_t s;
    s.do_reset = rst; s.r1 = r1; s.rep = rep; s.r2 = r2; s.rep2 = rep2;
    s.drop = drop; s.abort = abort; s.garbage = garb;
    s.pre_busy = pre; s.busy_len = blen; s.resp_dly = rdly; s.lt_dly = ldly;
    s.has_exp = 1'b1; s.exp_func = efunc; s.exp_err = eerr; s.exp_end = eend;
    return s;
  endfunction

  task automatic drive_idle();
    sb_if.i_Busy_SideBand      = 1'b0;
    sb_if.i_falling_edge_busy  = 1'b0;
    sb_if.i_RX_SbMessage       = 4'd0;
    sb_if.i_msg_valid          = 1'b0;
    sb_if.i_Start_Repeater     = 1'b0;
    sb_if.i_Lanes_Result       = 2'd0;
    sb_if.i_Lanes_Result_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    chk("reset func lanes", 32'(func), 32'd3);
    chk("reset train_error", 32'(err), 32'd0);
    chk("reset stage end", 32'(fin), 32'd0);
    chk("reset valid strobe", 32'(sb_if.o_ValidOutData), 32'd0);
    chk("reset tx msg", 32'(sb_if.o_TX_SbMessage), 32'd0);
    chk("reset msginfo", 32'(sb_if.o_msg_info_Lanes), 32'd0);
    chk("reset lane test", 32'(sb_if.o_Start_Lane_Test), 32'd0);
    chk("reset done repeater", 32'(sb_if.o_Done_Repeater), 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    model_func = 2'b11;
  endtask

  // Transaction-level expectation: which messages go out and how the stage ends.
  task automatic model(input scen_t s);
    exp_msg.delete(); exp_info.delete();
    exp_lt = 0; exp_done = 0; m_func = model_func; m_err = 1'b0; m_end = 1'b0;
    exp_msg.push_back(4'd1); exp_info.push_back(2'd0);
    if (s.drop) begin m_err = 1'b1; return; end
    exp_lt = 1;
    if (s.r1 == 2'd0) begin m_err = 1'b1; return; end
    exp_msg.push_back(4'd5); exp_info.push_back(s.r1);
    if (s.abort) return;
    m_func = s.r1;
    if (s.rep) begin
      exp_lt = 2;
      if (s.r2 == 2'd0) begin m_err = 1'b1; return; end
      exp_done = 1;
      exp_msg.push_back(4'd5); exp_info.push_back(s.r2);
      m_func = s.r2;
      if (s.rep2) begin m_err = 1'b1; return; end
    end
    exp_msg.push_back(4'd3); exp_info.push_back(2'd0);
    m_end = 1'b1;
  endtask

  task automatic run(input scen_t s);
    int busy_left, pre_cnt, resp_wait, lt_wait, rep_wait, ndeg, nlt;
    bit fe_next, aborted, prev_busy;
    logic [3:0] last_sent, resp_code;
    act_msg.delete(); act_info.delete();
    act_lt = 0; act_done = 0; busy_viol = 0; fe_idx = -1; err_idx = -1; expired = 1'b1;
    busy_left = 0; pre_cnt = s.pre_busy; resp_wait = -1; lt_wait = -1; rep_wait = -1;
    ndeg = 0; nlt = 0; fe_next = 1'b0; aborted = 1'b0; prev_busy = 1'b0;
    last_sent = 4'd0; resp_code = 4'd0;
    @(negedge CLK);
    en = 1'b0;
    drive_idle();
    @(negedge CLK);
    en = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      if (sb_if.o_ValidOutData) begin
        act_msg.push_back(sb_if.o_TX_SbMessage);
        act_info.push_back(sb_if.o_msg_info_Lanes);
        if (prev_busy) busy_viol++;
        last_sent = sb_if.o_TX_SbMessage;
        busy_left = s.busy_len;
      end
      if (sb_if.o_Start_Lane_Test) begin act_lt++; lt_wait = s.lt_dly; end
      if (sb_if.o_Done_Repeater) act_done++;
      if (err && err_idx < 0) err_idx = cyc;
      if (err || fin) begin expired = 1'b0; break; end
      drive_idle();
      if (fe_next) begin
        sb_if.i_falling_edge_busy = 1'b1;
        fe_next = 1'b0;
        resp_wait = s.resp_dly;
        resp_code = last_sent + 4'd1;
        if (last_sent == 4'd1) fe_idx = cyc;
      end else if (busy_left > 0) begin
        sb_if.i_Busy_SideBand = 1'b1;
        busy_left--;
        if (busy_left == 0) fe_next = 1'b1;
      end
      if (pre_cnt > 0) begin sb_if.i_Busy_SideBand = 1'b1; pre_cnt--; end
      if (lt_wait == 0) begin
        sb_if.i_Lanes_Result_valid = 1'b1;
        sb_if.i_Lanes_Result = (nlt == 0) ? s.r1 : s.r2;
        nlt++;
        lt_wait = -1;
      end else if (lt_wait > 0) begin
        lt_wait--;
      end
      if (rep_wait == 0) begin
        sb_if.i_Start_Repeater = 1'b1;
        rep_wait = -1;
      end else if (rep_wait > 0) begin
        rep_wait--;
      end
      if (resp_wait == 0) begin
        resp_wait = -1;
        if (resp_code == 4'd2 && s.drop) begin
        end else if (resp_code == 4'd6 && s.abort) begin
          en = 1'b0;
          aborted = 1'b1;
        end else begin
          sb_if.i_msg_valid = 1'b1;
          sb_if.i_RX_SbMessage = resp_code;
          if (resp_code == 4'd6) begin
            ndeg++;
            // Repeat request lands two cycles after the degrade response.
            if ((ndeg == 1 && s.rep) || (ndeg == 2 && s.rep2)) rep_wait = 1;
          end
        end
      end else if (resp_wait > 0) begin
        if (s.garbage && resp_wait == 1) begin
          sb_if.i_msg_valid = 1'b1;
          sb_if.i_RX_SbMessage = 4'hF;
        end
        resp_wait--;
      end
      prev_busy = sb_if.i_Busy_SideBand;
      if (aborted) begin expired = 1'b0; break; end
    end
  endtask

  task automatic check_scen(input scen_t s, input string t);
    model(s);
    chk({t, " finished in budget"}, 32'(expired), 32'd0);
    chk({t, " msg count"}, act_msg.size(), exp_msg.size());
    for (int i = 0; i < exp_msg.size() && i < act_msg.size(); i++) begin
      chk($sformatf("%s msg%0d code", t, i), 32'(act_msg[i]), 32'(exp_msg[i]));
      if (exp_msg[i] == 4'd5)
        chk($sformatf("%s msg%0d info", t, i), 32'(act_info[i]), 32'(exp_info[i]));
    end
    chk({t, " lane test pulses"}, act_lt, exp_lt);
    chk({t, " done repeater pulses"}, act_done, exp_done);
    chk({t, " strobe while busy"}, busy_viol, 0);
    if (s.has_exp) begin
      chk({t, " func lanes"}, 32'(func), 32'(s.exp_func));
      chk({t, " train_error"}, 32'(err), 32'(s.exp_err));
      chk({t, " stage end"}, 32'(fin), 32'(s.exp_end));
    end else begin
      chk({t, " func lanes"}, 32'(func), 32'(m_func));
      chk({t, " train_error"}, 32'(err), 32'(m_err));
      chk({t, " stage end"}, 32'(fin), 32'(m_end));
    end
    if (s.drop) chk({t, " timeout latency"}, err_idx - fe_idx, TO + 1);
    model_func = m_func;
  endtask

  initial begin
    scen_t tbl[9];
    scen_t s;
    //            rst r1 rp r2 rp2 drp abt grb pre bl rd ld  func err end
    tbl[0] = mk(1, 3, 0, 0, 0, 0, 0, 0, 0,  2, 3, 2, 2'd3, 0, 1);
    tbl[1] = mk(0, 1, 1, 2, 0, 0, 0, 0, 0,  1, 5, 4, 2'd2, 0, 1);
    tbl[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  2, 2, 1, 2'd3, 1, 0);
    tbl[3] = mk(0, 3, 1, 1, 1, 0, 0, 0, 0,  3, 1, 0, 2'd1, 1, 0);
    tbl[4] = mk(0, 3, 0, 0, 0, 1, 0, 0, 0,  2, 4, 1, 2'd1, 1, 0);
    tbl[5] = mk(0, 2, 0, 0, 0, 0, 0, 0, 15, 1, 6, 3, 2'd2, 0, 1);
    tbl[6] = mk(0, 3, 0, 0, 0, 0, 0, 1, 0,  2, 4, 2, 2'd3, 0, 1);
    tbl[7] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0,  1, 3, 2, 2'd3, 0, 0);
    tbl[8] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  2, 7, 5, 2'd1, 0, 1);

    drive_idle();
    model_func = 2'b11;
    apply_reset();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].do_reset) apply_reset();
      run(tbl[i]);
      if (tbl[i].abort) begin
        @(negedge CLK);
        chk("abort valid strobe", 32'(sb_if.o_ValidOutData), 32'd0);
        chk("abort tx msg", 32'(sb_if.o_TX_SbMessage), 32'd0);
        chk("abort msginfo", 32'(sb_if.o_msg_info_Lanes), 32'd0);
        chk("abort lane test", 32'(sb_if.o_Start_Lane_Test), 32'd0);
        chk("abort done repeater", 32'(sb_if.o_Done_Repeater), 32'd0);
      end
      check_scen(tbl[i], $sformatf("row%0d", i));
    end

    // Async reset in the middle of a sequence, right as start_req goes out.
    @(negedge CLK);
    en = 1'b0;
    drive_idle();
    @(negedge CLK);
    en = 1'b1;
    repeat (2) @(negedge CLK);
    chk("midreset strobe before", 32'(sb_if.o_ValidOutData), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset valid", 32'(sb_if.o_ValidOutData), 32'd0);
    chk("midreset tx msg", 32'(sb_if.o_TX_SbMessage), 32'd0);
    chk("midreset func lanes", 32'(func), 32'd3);
    @(negedge CLK);
    rst_n = 1'b1;
    model_func = 2'b11;

    for (int i = 0; i < 14; i++) begin
      s.do_reset = ($urandom_range(0, 3) == 0);
      s.r1       = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      s.rep      = 1'($urandom_range(0, 1));
      s.r2       = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      s.rep2     = ($urandom_range(0, 3) == 0);
      s.drop     = ($urandom_range(0, 9) == 0);
      s.abort    = 1'b0;
      s.garbage  = 1'($urandom_range(0, 1));
      s.pre_busy = int'($urandom_range(0, 6));
      s.busy_len = int'($urandom_range(1, 4));
      s.resp_dly = int'($urandom_range(1, 10));
      s.lt_dly   = int'($urandom_range(0, 8));
      s.has_exp  = 1'b0;
      s.exp_func = 2'd0;
      s.exp_err  = 1'b0;
      s.exp_end  = 1'b0;
      if (s.do_reset) apply_reset();
      run(s);
      check_scen(s, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/repairmb_initiator.md
Name: repairmb_initiator

Overview:
- Initiator (local-TX) side of the MBINIT.REPAIRMB sideband handshake; pairs with the REPAIRMB partner/responder.
- Sequence: sends start_req, runs the local lane test, sends apply_degrade_req carrying the functional-lane code, services one partner-requested repeat, then sends end_req.
- Sits in the MBINIT chain after REVERSALMB. Drives the sideband TX mux and the width-degrade logic.

Parameters:
- TIMEOUT_CYCLES, 16'd8000: max cycles to wait for a response or a lane-test result before train error.
- GUARD_CYCLES, 4: window after degrade_resp in which a partner repeat request is accepted.
- CNT_W, 16: width of the timeout counter.

Ports:
- CLK  in  1  clock
- rst_n  in  1  async active-low reset
- MBINIT_REVERSALMB_end  in  1  stage enable; low = abort to IDLE
- i_Busy_SideBand  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse when the sideband finishes a message
- i_RX_SbMessage  in  4  received message code
- i_msg_valid  in  1  i_RX_SbMessage valid
- i_Start_Repeater  in  1  partner repeat request pulse
- i_Lanes_Result  in  2  lane-test result: 11 = lanes 0-15, 01 = 0-7, 10 = 8-15, 00 = none
- i_Lanes_Result_valid  in  1  result strobe
- o_Start_Lane_Test  out  1  one-cycle pulse that starts the lane test
- o_Done_Repeater  out  1  one-cycle pulse when the repeat test is done
- o_TX_SbMessage  out  4  message code to send
- o_ValidOutData  out  1  one-cycle send strobe
- o_msg_info_Lanes  out  2  msginfo lane code for degrade_req
- o_Functional_Lanes  out  2  latched lane code to width degrade
- o_train_error  out  1  sticky error
- o_MBINIT_REPAIRMB_end  out  1  stage complete, held

Behaviour:
- Message codes: start_req 0001, start_resp 0010, end_req 0011, end_resp 0100, apply_degrade_req 0101, apply_degrade_resp 0110.
- Reset values:
  - o_Functional_Lanes = 2'b11.
  - o_TX_SbMessage = 0, o_msg_info_Lanes = 0.
  - All other outputs = 0.
  - State = IDLE; repeat_done flag = 0; counters = 0.
- Outputs are registered and decoded from the next state. Pulses are high for exactly one cycle, on entry to the state named below.
- States and transitions:
  - IDLE -> BUSY_START when enable is high.
  - BUSY_START -> START_REQ when i_Busy_SideBand = 0.
  - START_REQ: on entry, o_ValidOutData = 1 and o_TX_SbMessage = start_req. Moves to WAIT_START_RESP on i_falling_edge_busy.
  - WAIT_START_RESP -> LANE_TEST on i_msg_valid with code start_resp.
  - LANE_TEST: pulses o_Start_Lane_Test on entry. On i_Lanes_Result_valid it latches i_Lanes_Result into lanes_r.
    - If lanes_r = 00 -> ERROR.
    - Else if repeat_done = 1 -> pulse o_Done_Repeater, then BUSY_DEGRADE.
    - Else -> BUSY_DEGRADE.
  - BUSY_DEGRADE -> DEGRADE_REQ when i_Busy_SideBand = 0.
  - DEGRADE_REQ: sends apply_degrade_req with o_msg_info_Lanes = lanes_r. Moves to WAIT_DEGRADE_RESP on i_falling_edge_busy.
  - WAIT_DEGRADE_RESP -> DECIDE on apply_degrade_resp. On that transition, o_Functional_Lanes <= lanes_r.
  - DECIDE counts GUARD_CYCLES:
    - i_Start_Repeater with repeat_done = 0 -> set repeat_done, go to LANE_TEST.
    - i_Start_Repeater with repeat_done = 1 -> ERROR.
    - Window expiry -> BUSY_END.
  - BUSY_END -> END_REQ when i_Busy_SideBand = 0.
  - END_REQ: sends end_req. Moves to WAIT_END_RESP on i_falling_edge_busy.
  - WAIT_END_RESP -> DONE on end_resp.
  - DONE: holds o_MBINIT_REPAIRMB_end = 1.
  - ERROR: holds o_train_error = 1.
- Timeout:
  - The counter clears on every state change.
  - It increments only in WAIT_START_RESP, WAIT_DEGRADE_RESP, WAIT_END_RESP and LANE_TEST.
  - Reaching TIMEOUT_CYCLES-1 -> ERROR.
- Unexpected message codes with i_msg_valid are ignored; the state is held.
- If a message arrives in the same cycle as a timeout, the message wins.
- i_Start_Repeater outside DECIDE is ignored.
- Enable low in any state, including DONE and ERROR, goes to IDLE on the next edge:
  - clears o_train_error, o_MBINIT_REPAIRMB_end, repeat_done and the counters;
  - keeps o_Functional_Lanes.
- Async reset mid-sequence forces all reset values immediately.

Test Plan:
- Nominal path: enable high, busy low, partner answers each request within 10 cycles, i_Lanes_Result = 11.
  - Required: messages 0001, 0101 (msginfo 11), 0011 in order, one strobe each.
  - o_Functional_Lanes = 11; o_MBINIT_REPAIRMB_end = 1 held.
- Degrade with one repeat:
  - Stimulus: first result 01; i_Start_Repeater pulsed 2 cycles after degrade_resp; second result 10.
  - Required: o_Start_Lane_Test pulses twice; o_Done_Repeater pulses once.
  - A second degrade_req goes out with msginfo 10; then end_req; o_Functional_Lanes = 10.
- Failures:
  - Lane result 00 -> o_train_error = 1 and no degrade_req sent.
  - A second i_Start_Repeater after the repeat -> o_train_error = 1.
- Timeout: start_resp never arrives -> o_train_error rises exactly TIMEOUT_CYCLES cycles after entering WAIT_START_RESP (use TIMEOUT_CYCLES = 20 in the bench).
- Busy gating: i_Busy_SideBand held high for 15 cycles -> o_ValidOutData stays 0 until busy falls, then pulses once.
- Abort and garbage:
  - Enable dropped in WAIT_DEGRADE_RESP -> IDLE next cycle, all outputs 0 except o_Functional_Lanes.
  - Re-enable -> start_req is re-sent.
  - Garbage code 1111 with valid -> state unchanged.
